sort_ctrl: RTL

Sequencer for the 6-entry data/flag sorter. It latches an unsorted vector on `start` and runs odd-even transposition phases, one per clock. Each phase uses the same compare-exchange rule as the sort cells, and the controller alternates the phase parity. It reports completion with a `busy`/`done` handshake and holds the sorted vector until the next load. It sits between the host/FSM that issues sort requests and the consumers of `sort_data`/`sort_flag`.

---
 rtl/sort_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sort_ctrl.sv
// Odd-even transposition sequencer for the data/flag sorter: one phase per clock, busy/done handshake.
// Optional SORT_EARLY_EXIT_EN: finish once an even and an odd phase in a row make no swaps.

module sort_cell #(
  parameter int DW = 7,
  parameter int FW = 6
) (
  input  logic          en,
  input  logic          mode,
  input  logic [DW-1:0] lo_d,
  input  logic [DW-1:0] hi_d,
  input  logic [FW-1:0] lo_f,
  input  logic [FW-1:0] hi_f,
  output logic [DW-1:0] nlo_d,
  output logic [DW-1:0] nhi_d,
  output logic [FW-1:0] nlo_f,
  output logic [FW-1:0] nhi_f
);
  logic swap;

  // Equal data only swaps on flags in mode 1; mode 0 keeps the sort stable.
  assign swap  = en && ((lo_d > hi_d) || (mode && (lo_d == hi_d) && (lo_f > hi_f)));
  assign nlo_d = swap ? hi_d : lo_d;
  assign nhi_d = swap ? lo_d : hi_d;
  assign nlo_f = swap ? hi_f : lo_f;
  assign nhi_f = swap ? lo_f : hi_f;
endmodule

module sort_ctrl #(
  parameter int SORT_NUMBER      = 6,
  parameter int SORT_DATA_LENGTH = 7,
  parameter int SORT_FLAG_LENGTH = 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   mode,
  input  logic [SORT_DATA_LENGTH*SORT_NUMBER-1:0] unsort_data,
  input  logic [SORT_FLAG_LENGTH*SORT_NUMBER-1:0] unsort_flag,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   phase,
  output logic [2:0]                             phase_cnt,
  output logic [SORT_DATA_LENGTH*SORT_NUMBER-1:0] sort_data,
  output logic [SORT_FLAG_LENGTH*SORT_NUMBER-1:0] sort_flag
);
  localparam int N  = SORT_NUMBER;
  localparam int DW = SORT_DATA_LENGTH;
  localparam int FW = SORT_FLAG_LENGTH;
  localparam logic [2:0] LAST_CNT = 3'(N - 1);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t state, state_nxt;
  logic   load, step, last_phase;
  logic   mode_q;

  logic [N-1:0][DW-1:0] data_q, nxt_d;
  logic [N-1:0][FW-1:0] flag_q, nxt_f;
  logic [N-2:0][DW-1:0] c_lo_d, c_hi_d;
  logic [N-2:0][FW-1:0] c_lo_f, c_hi_f;
  logic [N-2:0]         pair_en;

  // Cell i owns pair (i+1, i); even phase enables even i, odd phase odd i.
  for (genvar i = 0; i < N - 1; i++) begin : g_cell
    assign pair_en[i] = (phase == ((i % 2) == 1));
    sort_cell #(.DW(DW), .FW(FW)) u_cell (
      .en    (pair_en[i]),
      .mode  (mode_q),
      .lo_d  (data_q[i]),
      .hi_d  (data_q[i+1]),
      .lo_f  (flag_q[i]),
      .hi_f  (flag_q[i+1]),
      .nlo_d (c_lo_d[i]),
      .nhi_d (c_hi_d[i]),
      .nlo_f (c_lo_f[i]),
      .nhi_f (c_hi_f[i])
    );
  end

  // A disabled cell passes its inputs through, so each slot only needs to know
  // whether the pair below it is active.
  for (genvar j = 0; j < N; j++) begin : g_slot
    if (j == 0) begin : g_lo
      assign nxt_d[j] = c_lo_d[0];
      assign nxt_f[j] = c_lo_f[0];
    end else if (j == N - 1) begin : g_hi
      assign nxt_d[j] = c_hi_d[N-2];
      assign nxt_f[j] = c_hi_f[N-2];
    end else begin : g_mid
      assign nxt_d[j] = pair_en[j-1] ? c_hi_d[j-1] : c_lo_d[j];
      assign nxt_f[j] = pair_en[j-1] ? c_hi_f[j-1] : c_lo_f[j];
    end
  end

`ifdef SORT_EARLY_EXIT_EN
  logic quiet_q, swapped;

  // A swap always changes the vector, so any difference means the phase did work.
  assign swapped    = (nxt_d != data_q) || (nxt_f != flag_q);
  assign last_phase = (phase_cnt == LAST_CNT) || (quiet_q && !swapped);

  always_ff @(posedge clk) begin
    if (rst || load) quiet_q <= 1'b0;
    else if (step)   quiet_q <= !swapped;
  end
`else
  assign last_phase = (phase_cnt == LAST_CNT);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = SORT;
      end
      SORT: begin
        step = 1'b1;
        if (last_phase) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      phase     <= 1'b0;
      phase_cnt <= 3'd0;
      mode_q    <= 1'b0;
      data_q    <= '0;
      flag_q    <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      if (load) begin
        data_q    <= unsort_data;
        flag_q    <= unsort_flag;
        mode_q    <= mode;
        phase     <= 1'b0;
        phase_cnt <= 3'd0;
      end else if (step) begin
        data_q    <= nxt_d;
        flag_q    <= nxt_f;
        phase     <= ~phase;
        phase_cnt <= phase_cnt + 3'd1;
      end
    end
  end

  assign sort_data = data_q;
  assign sort_flag = flag_q;
endmodule
